// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, config word layout and word-size limits.
// Both uart_tx and uart_rx import this so that their framing always agrees.
package uart_pkg;

    typedef enum logic [6:0] {
        ST_READY  = 7'b0000001,
        ST_SYNC   = 7'b0000010,
        ST_START  = 7'b0000100,
        ST_DATA   = 7'b0001000,
        ST_PARITY = 7'b0010000,
        ST_STOP   = 7'b0100000,
        ST_DONE   = 7'b1000000
    } uart_state_t;

    localparam int CFG_STOP_BIT   = 6;
    localparam int CFG_PARITY_BIT = 5;
    localparam int CFG_SIZE_MSB   = 4;
    localparam int CFG_SIZE_LSB   = 1;
    localparam int CFG_STORE_BIT  = 0;

    localparam int WORD_WIDTH = 9;

    localparam logic [3:0] WORD_MIN     = 4'd5;
    localparam logic [3:0] WORD_MAX     = 4'd9;
    localparam logic [3:0] WORD_DEFAULT = 4'd8;

    function automatic logic [3:0] clamp_word_size(input logic [3:0] size);
        if (size < WORD_MIN) begin
            return WORD_MIN;
        end else if (size > WORD_MAX) begin
            return WORD_MAX;
        end
        return size;
    endfunction

    // Bits at or above the active word size never reach the line or the parity.
    function automatic logic [WORD_WIDTH-1:0] mask_word(input logic [WORD_WIDTH-1:0] word,
                                                       input logic [3:0] size);
        logic [WORD_WIDTH-1:0] masked;
        for (int i = 0; i < WORD_WIDTH; i++) begin
            masked[i] = word[i] & (i < int'(size));
        end
        return masked;
    endfunction

endpackage

// File: rtl/parity_checker.sv
// Even-parity generator shared with uart_rx: output is the XOR of all word bits.
module parity_checker #(
    parameter int WORD_SIZE = 9
) (
    input  logic [WORD_SIZE-1:0] data,
    output logic                 parity
);

    assign parity = ^data;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: latches one word per handshake and serialises start, data, optional
// parity and 1 or 2 stop bits onto an idle-high line, one bit per external baud tick.
module uart_tx
    import uart_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [6:0] i_config,
    input  logic [8:0] i_tx_parallel,
    input  logic       i_tx_valid,
    input  logic       i_uart_clk_enable,
    output logic       o_tx,
    output logic       o_ready,
    output logic       o_done
);

    uart_state_t           state;
    logic [3:0]            cnt;
    logic [WORD_WIDTH-1:0] word_q;
    logic [WORD_WIDTH-1:0] shift_q;
    logic [3:0]            cfg_size;
    logic                  cfg_parity;
    logic                  cfg_stop2;
    logic                  parity_bit;

    parity_checker #(
        .WORD_SIZE(WORD_WIDTH)
    ) u_parity (
        .data   (word_q),
        .parity (parity_bit)
    );

    // o_tx is loaded with the bit of the state being entered, so the line only moves on tick edges.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= ST_READY;
            cnt        <= 4'd0;
            word_q     <= '0;
            shift_q    <= '0;
            cfg_size   <= WORD_DEFAULT;
            cfg_parity <= 1'b0;
            cfg_stop2  <= 1'b0;
            o_tx       <= 1'b1;
            o_ready    <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                ST_READY: begin
                    o_tx <= 1'b1;
                    if (o_ready && i_tx_valid) begin
                        word_q  <= mask_word(i_tx_parallel, cfg_size);
                        shift_q <= mask_word(i_tx_parallel, cfg_size);
                        o_ready <= 1'b0;
                        state   <= ST_SYNC;
                    end else begin
                        o_ready <= 1'b1;
                        if (o_ready && i_config[CFG_STORE_BIT]) begin
                            cfg_size   <= clamp_word_size(i_config[CFG_SIZE_MSB:CFG_SIZE_LSB]);
                            cfg_parity <= i_config[CFG_PARITY_BIT];
                            cfg_stop2  <= i_config[CFG_STOP_BIT];
                        end
                    end
                end
                ST_SYNC: begin
                    if (i_uart_clk_enable) begin
                        o_tx  <= 1'b0;
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (i_uart_clk_enable) begin
                        o_tx  <= shift_q[0];
                        cnt   <= 4'd0;
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (i_uart_clk_enable) begin
                        if (cnt == cfg_size - 4'd1) begin
                            cnt <= 4'd0;
                            if (cfg_parity) begin
                                o_tx  <= parity_bit;
                                state <= ST_PARITY;
                            end else begin
                                o_tx  <= 1'b1;
                                state <= ST_STOP;
                            end
                        end else begin
                            cnt     <= cnt + 4'd1;
                            shift_q <= shift_q >> 1;
                            o_tx    <= shift_q[1];
                        end
                    end
                end
                ST_PARITY: begin
                    if (i_uart_clk_enable) begin
                        o_tx  <= 1'b1;
                        cnt   <= 4'd0;
                        state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (i_uart_clk_enable) begin
                        if (cnt == {3'b000, cfg_stop2}) begin
                            o_done <= 1'b1;
                            state  <= ST_DONE;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                end
                ST_DONE: begin
                    o_ready <= 1'b1;
                    state   <= ST_READY;
                end
                default: begin
                    o_tx    <= 1'b1;
                    o_ready <= 1'b0;
                    state   <= ST_READY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a queue-based frame model predicts the line, ready and done
// every cycle, while directed frames pin the model against hand-computed bit sequences.
module tb_uart_tx;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic [6:0] i_config = 7'd0;
    logic [8:0] i_tx_parallel = 9'd0;
    logic       i_tx_valid = 1'b0;
    logic       i_uart_clk_enable;
    logic       o_tx;
    logic       o_ready;
    logic       o_done;

    int tests_run = 0;
    int tests_failed = 0;

    int tick_period = 16;
    int tick_cnt = 0;

    bit check_en = 0;
    bit cap_en = 0;
    bit done_en = 0;
    int done_cnt = 0;
    bit cap_q[$];

    // Model: phase 0 idle, 1 sending (sync period then queued frame bits), 2 done pulse.
    int       m_phase = 0;
    bit       m_q[$];
    bit       m_tx = 1'b1;
    bit       m_ready = 1'b0;
    bit       m_done = 1'b0;
    int       m_size = 8;
    bit       m_par = 1'b0;
    bit       m_stop2 = 1'b0;
    int       m_sent = 0;

    uart_tx dut (
        .i_clk             (i_clk),
        .i_rst             (i_rst),
        .i_config          (i_config),
        .i_tx_parallel     (i_tx_parallel),
        .i_tx_valid        (i_tx_valid),
        .i_uart_clk_enable (i_uart_clk_enable),
        .o_tx              (o_tx),
        .o_ready           (o_ready),
        .o_done            (o_done)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        i_uart_clk_enable = 1'b0;
        forever begin
            @(posedge i_clk);
            #2;
            tick_cnt++;
            if (tick_cnt >= tick_period) begin
                tick_cnt = 0;
                i_uart_clk_enable = 1'b1;
            end else begin
                i_uart_clk_enable = 1'b0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int clampSize(input int raw);
        if (raw < 5) return 5;
        if (raw > 9) return 9;
        return raw;
    endfunction

    always @(posedge i_clk) begin
        if (i_rst) begin
            m_phase = 0;
            m_q.delete();
            m_tx = 1'b1;
            m_ready = 1'b0;
            m_done = 1'b0;
            m_size = 8;
            m_par = 1'b0;
            m_stop2 = 1'b0;
            m_sent = 0;
        end else begin
            m_done = 1'b0;
            case (m_phase)
                0: begin
                    m_tx = 1'b1;
                    if (m_ready && i_tx_valid) begin
                        logic [8:0] d;
                        d = 9'd0;
                        for (int i = 0; i < m_size; i++) d[i] = i_tx_parallel[i];
                        m_q.delete();
                        m_q.push_back(1'b0);
                        for (int i = 0; i < m_size; i++) m_q.push_back(d[i]);
                        if (m_par) m_q.push_back(^d);
                        m_q.push_back(1'b1);
                        if (m_stop2) m_q.push_back(1'b1);
                        m_phase = 1;
                        m_ready = 1'b0;
                        m_sent = 0;
                    end else begin
                        if (m_ready && i_config[0]) begin
                            m_size = clampSize(int'(i_config[4:1]));
                            m_par = i_config[5];
                            m_stop2 = i_config[6];
                        end
                        m_ready = 1'b1;
                    end
                end
                1: begin
                    if (i_uart_clk_enable) begin
                        if (m_q.size() > 0) begin
                            m_tx = m_q.pop_front();
                            m_sent++;
                        end else begin
                            m_done = 1'b1;
                            m_phase = 2;
                        end
                    end
                end
                default: begin
                    m_phase = 0;
                    m_ready = 1'b1;
                end
            endcase
        end
    end

    always @(negedge i_clk) begin
        if (check_en) begin
            checkOutput("cycle", {13'd0, o_tx, o_ready, o_done}, {13'd0, m_tx, m_ready, m_done});
        end
        if (cap_en && m_phase == 1 && i_uart_clk_enable) cap_q.push_back(o_tx);
        if (done_en && o_done) done_cnt++;
    end

    task automatic waitModelIdle(input int budget);
        int n;
        n = 0;
        while (!(m_phase == 0 && m_ready) && n < budget) begin
            @(negedge i_clk);
            n++;
        end
        if (n >= budget) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL idle_timeout: still busy after %0d cycles, required idle", budget);
        end
    endtask

    // Present a word (optionally with a config word alongside) for exactly one cycle.
    task automatic applyStimulus(input logic [8:0] data, input logic [6:0] cfg);
        waitModelIdle(400);
        i_tx_parallel = data;
        i_config = cfg;
        i_tx_valid = 1'b1;
        @(negedge i_clk);
        i_tx_valid = 1'b0;
        i_config = 7'd0;
    endtask

    task automatic storeConfig(input logic [6:0] cfg);
        waitModelIdle(400);
        i_config = cfg | 7'd1;
        @(negedge i_clk);
        i_config = 7'd0;
    endtask

    task automatic startCapture();
        cap_q.delete();
        cap_en = 1'b1;
        done_cnt = 0;
        done_en = 1'b1;
    endtask

    task automatic checkCapture(input string name, input int exp_len, input logic [15:0] exp_bits);
        logic [15:0] v;
        waitModelIdle(400);
        cap_en = 1'b0;
        done_en = 1'b0;
        v = 16'd0;
        foreach (cap_q[i]) v = {v[14:0], cap_q[i]};
        checkOutput({name, "_len"}, 16'(cap_q.size()), 16'(exp_len));
        checkOutput({name, "_bits"}, v, exp_bits);
        checkOutput({name, "_done"}, 16'(done_cnt), 16'd1);
    endtask

    initial begin
        repeat (3) @(negedge i_clk);
        check_en = 1'b1;
        checkOutput("reset_tx", {15'd0, o_tx}, 16'd1);
        checkOutput("reset_ready", {15'd0, o_ready}, 16'd0);
        checkOutput("reset_done", {15'd0, o_done}, 16'd0);
        i_rst = 1'b0;
        @(negedge i_clk);
        checkOutput("ready_after_reset", {15'd0, o_ready}, 16'd1);

        // 8N1, 0x0A5: sync then 0,1,0,1,0,0,1,0,1,1.
        tick_period = 16;
        startCapture();
        applyStimulus(9'h0A5, 7'd0);
        checkCapture("frame_8n1", 11, 16'b10101001011);

        // 9 bits with parity, 0x1FF: nine ones, parity 1, one stop.
        storeConfig(7'b0110011);
        tick_period = 5;
        startCapture();
        applyStimulus(9'h1FF, 7'd0);
        checkCapture("frame_9e1", 13, 16'b1011111111111);

        // Size 3 clamps to 5, two stop bits.
        storeConfig(7'b1000111);
        tick_period = 3;
        startCapture();
        applyStimulus(9'h0FF, 7'd0);
        checkCapture("frame_clamp", 9, 16'b101111111);

        // Word and store together: old 5N2 config used, store dropped.
        tick_period = 6;
        startCapture();
        applyStimulus(9'h0AA, 7'b0110011);
        checkCapture("collide_first", 9, 16'b100101011);
        startCapture();
        applyStimulus(9'h1FF, 7'd0);
        checkCapture("collide_second", 9, 16'b101111111);

        // Reset while data bit 3 is on the line.
        tick_period = 8;
        done_cnt = 0;
        done_en = 1'b1;
        applyStimulus(9'h155, 7'd0);
        begin
            int n;
            n = 0;
            while (m_sent < 5 && n < 200) begin
                @(negedge i_clk);
                n++;
            end
            if (n >= 200) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL bit3_timeout: data bit 3 not reached in %0d cycles", n);
            end
        end
        repeat (2) @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        checkOutput("midreset_tx", {15'd0, o_tx}, 16'd1);
        checkOutput("midreset_ready", {15'd0, o_ready}, 16'd0);
        i_rst = 1'b0;
        @(negedge i_clk);
        checkOutput("midreset_ready_rise", {15'd0, o_ready}, 16'd1);
        repeat (40) @(negedge i_clk);
        done_en = 1'b0;
        checkOutput("midreset_no_done", 16'(done_cnt), 16'd0);
        startCapture();
        applyStimulus(9'h0A5, 7'd0);
        checkCapture("post_reset_8n1", 11, 16'b10101001011);

        // Random configs, words, baud rates and ignored strobes while busy.
        for (int k = 0; k < 40; k++) begin
            logic [6:0] cfg;
            logic [8:0] data;
            cfg = 7'($urandom_range(0, 127));
            data = 9'($urandom_range(0, 511));
            tick_period = $urandom_range(2, 12);
            if ($urandom_range(0, 2) != 0) storeConfig(cfg);
            repeat ($urandom_range(0, 4)) @(negedge i_clk);
            applyStimulus(data, ($urandom_range(0, 3) == 0) ? (7'($urandom_range(0, 127)) | 7'd1) : 7'd0);
            while (m_phase == 1) begin
                if (m_q.size() > 1 && $urandom_range(0, 5) == 0) begin
                    i_tx_valid = 1'b1;
                    i_tx_parallel = 9'($urandom_range(0, 511));
                    i_config = 7'($urandom_range(0, 127));
                end
                @(negedge i_clk);
                i_tx_valid = 1'b0;
                i_config = 7'd0;
            end
            waitModelIdle(400);
        end

        repeat (5) @(negedge i_clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
